// File: rtl/eight_bit_serial_subtractor.sv
// Bit-serial A - B - Bin, LSB first, through one full-subtractor cell and a borrow flop.
// A start/busy/done handshake delivers the registered difference and borrow-out.
module eight_bit_serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Borrow
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;

    logic bit_a, bit_b, bit_d, br_next;

    // Full-subtractor cell on the current LSBs.
    assign bit_a   = sa_q[0];
    assign bit_b   = sb_q[0];
    assign bit_d   = bit_a ^ bit_b ^ br_q;
    assign br_next = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        case (state_q)
            IDLE, DONE: begin
                // DONE doubles as an accept slot so held start gives back-to-back results.
                if (start) begin
                    sa_d    = A;
                    sb_d    = B;
                    br_d    = Bin;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                acc_d = {bit_d, acc_q[WIDTH-1:1]};
                br_d  = br_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    diff_d   = {bit_d, acc_q[WIDTH-1:1]};
                    borrow_d = br_next;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q == RUN);
        done   = (state_q == DONE);
        Diff   = diff_q;
        Borrow = borrow_q;
    end

endmodule

// File: tb/tb_eight_bit_serial_subtractor.sv
// Directed and random checks of the serial subtractor: latency, handshake,
// reset abort, back-to-back throughput and adder round-trip.
module tb_eight_bit_serial_subtractor;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] A;
    logic [7:0] B;
    logic       Bin;
    logic       busy;
    logic       done;
    logic [7:0] Diff;
    logic       Borrow;

    int tests_run;
    int tests_failed;

    eight_bit_serial_subtractor #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .A      (A),
        .B      (B),
        .Bin    (Bin),
        .busy   (busy),
        .done   (done),
        .Diff   (Diff),
        .Borrow (Borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle start pulse, then wait (bounded) for done; returns result and timing.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                          output logic [7:0] d, output logic br,
                          output int lat, output int busy_cnt, output int overlap);
        @(negedge clk);
        A = a; B = b; Bin = bin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0; busy_cnt = 0; overlap = 0;
        while (!done && lat < 30) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        if (busy && done) overlap++;
        d  = Diff;
        br = Borrow;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; A = 8'hAA; B = 8'h55; Bin = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({busy, done, Borrow, Diff} !== 11'd0) begin
            tests_failed++;
            $display("FAIL reset_hold: busy=%b done=%b Diff=%0d Borrow=%b, want all 0", busy, done, Diff, Borrow);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({busy, done, Borrow, Diff} !== 11'd0) begin
            tests_failed++;
            $display("FAIL reset_release: busy=%b done=%b Diff=%0d Borrow=%b, want all 0", busy, done, Diff, Borrow);
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_basic();
        logic [7:0] d; logic br; int lat, bc, ov;
        run_op(8'd60, 8'd50, 1'b0, d, br, lat, bc, ov);
        $display("[TB] basic 60-50-0 -> Diff=%0d Borrow=%b lat=%0d busy=%0d", d, br, lat, bc);
        tests_run++;
        if (lat !== 8) begin tests_failed++; $display("FAIL basic_latency: got %0d, want 8", lat); end
        tests_run++;
        if (bc !== 8) begin tests_failed++; $display("FAIL basic_busy_cycles: got %0d, want 8", bc); end
        tests_run++;
        if (ov !== 0) begin tests_failed++; $display("FAIL basic_busy_done_overlap: got %0d, want 0", ov); end
        tests_run++;
        if ({br, d} !== {1'b0, 8'd10}) begin
            tests_failed++; $display("FAIL basic_result: got Diff=%0d Borrow=%b, want 10/0", d, br);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0) begin tests_failed++; $display("FAIL basic_done_pulse: done=%b one cycle later, want 0", done); end
        tests_run++;
        if ({br, d} !== {Borrow, Diff} || Diff !== 8'd10) begin
            tests_failed++; $display("FAIL basic_hold: Diff=%0d Borrow=%b, want 10/0 held", Diff, Borrow);
        end
    endtask

    task automatic test_vectors();
        logic [7:0] va [5]  = '{8'd100, 8'd0,   8'd255, 8'd200, 8'd5};
        logic [7:0] vb [5]  = '{8'd100, 8'd0,   8'd255, 8'd20,  8'd11};
        logic       vc [5]  = '{1'b1,   1'b1,   1'b0,   1'b0,   1'b1};
        logic [7:0] ed [5]  = '{8'd255, 8'd255, 8'd0,   8'd180, 8'd249};
        logic       eb [5]  = '{1'b1,   1'b1,   1'b0,   1'b0,   1'b1};
        logic [7:0] d; logic br; int lat, bc, ov;
        for (int i = 0; i < 5; i++) begin
            run_op(va[i], vb[i], vc[i], d, br, lat, bc, ov);
            $display("[TB] vec %0d-%0d-%0d -> Diff=%0d Borrow=%b", va[i], vb[i], vc[i], d, br);
            tests_run++;
            if ({br, d} !== {eb[i], ed[i]} || lat !== 8) begin
                tests_failed++;
                $display("FAIL vector_%0d: got Diff=%0d Borrow=%b lat=%0d, want %0d/%b lat 8", i, d, br, lat, ed[i], eb[i]);
            end
        end
    endtask

    task automatic test_start_in_run();
        int dones; int cyc;
        @(negedge clk);
        A = 8'd90; B = 8'd33; Bin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        A = 8'd1; B = 8'd2; Bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (cyc = 0; cyc < 20; cyc++) begin
            if (done) begin
                dones++;
                tests_run++;
                if ({Borrow, Diff} !== {1'b0, 8'd56}) begin
                    tests_failed++; $display("FAIL start_in_run_result: got Diff=%0d Borrow=%b, want 56/0", Diff, Borrow);
                end
            end
            @(negedge clk);
        end
        $display("[TB] start-in-run 90-33-1 -> dones=%0d", dones);
        tests_run++;
        if (dones !== 1) begin tests_failed++; $display("FAIL start_in_run_dones: got %0d, want 1", dones); end
    endtask

    task automatic test_reset_midrun();
        int dones;
        logic [7:0] d; logic br; int lat, bc, ov;
        @(negedge clk);
        A = 8'd77; B = 8'd3; Bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({busy, done, Borrow, Diff} !== 11'd0) begin
            tests_failed++;
            $display("FAIL midrun_reset_outputs: busy=%b done=%b Diff=%0d Borrow=%b, want all 0", busy, done, Diff, Borrow);
        end
        #2 rst_n = 1'b1;
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        tests_run++;
        if (dones !== 0) begin tests_failed++; $display("FAIL midrun_reset_no_done: activity cycles %0d, want 0", dones); end
        run_op(8'd20, 8'd0, 1'b0, d, br, lat, bc, ov);
        $display("[TB] after reset 20-0-0 -> Diff=%0d Borrow=%b", d, br);
        tests_run++;
        if ({br, d} !== {1'b0, 8'd20} || lat !== 8) begin
            tests_failed++; $display("FAIL midrun_reset_next_op: got Diff=%0d Borrow=%b lat=%0d, want 20/0 lat 8", d, br, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] oa [3] = '{8'd9,  8'd3,   8'd250};
        logic [7:0] ob [3] = '{8'd4,  8'd7,   8'd249};
        logic       oc [3] = '{1'b0,  1'b0,   1'b1};
        logic [7:0] ed [3] = '{8'd5,  8'd252, 8'd0};
        logic       eb [3] = '{1'b0,  1'b1,   1'b0};
        int         et [3] = '{8, 17, 26};
        int k;
        @(negedge clk);
        A = oa[0]; B = ob[0]; Bin = oc[0]; start = 1'b1;
        @(negedge clk);
        A = oa[1]; B = ob[1]; Bin = oc[1];
        k = 0;
        for (int t = 0; t < 40; t++) begin
            if (done && k < 3) begin
                $display("[TB] b2b op %0d at t=%0d -> Diff=%0d Borrow=%b", k, t, Diff, Borrow);
                tests_run++;
                if (t !== et[k] || {Borrow, Diff} !== {eb[k], ed[k]}) begin
                    tests_failed++;
                    $display("FAIL back_to_back_%0d: t=%0d Diff=%0d Borrow=%b, want t=%0d %0d/%b", k, t, Diff, Borrow, et[k], ed[k], eb[k]);
                end
                k++;
                if (k < 3) begin A = oa[k]; B = ob[k]; Bin = oc[k]; end
                else start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        tests_run++;
        if (k !== 3) begin tests_failed++; $display("FAIL back_to_back_count: got %0d results, want 3", k); end
    endtask

    task automatic test_random();
        logic [7:0] a, b, d; logic c, br; logic [8:0] exp9;
        int lat, bc, ov, bad;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            c = 1'($urandom_range(0, 1));
            exp9 = {1'b0, a} - {1'b0, b} - {8'd0, c};
            run_op(a, b, c, d, br, lat, bc, ov);
            tests_run++;
            if ({br, d} !== exp9 || lat !== 8) begin
                tests_failed++; bad++;
                $display("FAIL random_%0d: %0d-%0d-%0d got Diff=%0d Borrow=%b, want %0d/%b", i, a, b, c, d, br, exp9[7:0], exp9[8]);
            end
        end
        $display("[TB] random 1000 ops, %0d bad", bad);
    endtask

    task automatic test_adder_roundtrip();
        logic [7:0] va [5] = '{8'd200, 8'd255, 8'd10, 8'd0, 8'd128};
        logic [7:0] vb [5] = '{8'd100, 8'd255, 8'd20, 8'd0, 8'd128};
        logic       vc [5] = '{1'b1,   1'b1,   1'b0,  1'b0, 1'b0};
        logic [8:0] sum; logic [7:0] d; logic br; int lat, bc, ov;
        for (int i = 0; i < 5; i++) begin
            sum = {1'b0, va[i]} + {1'b0, vb[i]} + {8'd0, vc[i]};
            run_op(sum[7:0], vb[i], vc[i], d, br, lat, bc, ov);
            $display("[TB] roundtrip A=%0d B=%0d Cin=%0d Sum=%0d -> Diff=%0d Borrow=%b", va[i], vb[i], vc[i], sum, d, br);
            tests_run++;
            if (d !== va[i] || br !== sum[8]) begin
                tests_failed++;
                $display("FAIL roundtrip_%0d: got Diff=%0d Borrow=%b, want %0d/%b", i, d, br, va[i], sum[8]);
            end
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_basic();
        test_vectors();
        test_start_in_run();
        test_reset_midrun();
        test_back_to_back();
        test_random();
        test_adder_roundtrip();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/eight_bit_serial_subtractor.md
# eight_bit_serial_subtractor

Bit-serial 8-bit subtractor with borrow-in: the counterpart to the eight-bit ripple full adder. It computes A − B − Bin one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop. A start/busy/done handshake delivers a registered difference and borrow-out. It serves area-constrained datapaths, and it gives the adder benches a check path, since (A + B + Cin) − B − Cin must return A.

## Interface
- WIDTH, default 8: operand width in bits; also the number of serial bit-cycles.
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE or DONE.
- A  input  WIDTH  minuend; captured on the accepting edge.
- B  input  WIDTH  subtrahend; captured on the accepting edge.
- Bin  input  1  borrow-in; captured on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when Diff and Borrow are updated.
- Diff  output  WIDTH  registered (A − B − Bin) mod 2^WIDTH.
- Borrow  output  1  registered borrow-out: 1 iff A < B + Bin (unsigned).

## Operation
- States:
  - IDLE: wait for start. On start, go to RUN.
  - RUN: process one bit per cycle. After WIDTH bit-cycles, go to DONE.
  - DONE: lasts one cycle. Go to RUN if start is high, otherwise IDLE.
- Accept (start=1 in IDLE or DONE):
  - Load shift registers sa←A and sb←B.
  - Set borrow flop br←Bin, bit counter cnt←0, shift accumulator acc←0.
- Each RUN cycle, with a=sa[0] and b=sb[0]:
  - d = a ^ b ^ br.
  - br_next = (~a & b) | (~(a ^ b) & br).
  - sa and sb shift right by one.
  - acc shifts right with d entering at the MSB.
  - cnt increments.
- Completion: on the edge where cnt reaches WIDTH−1:
  - Diff←{d, acc[WIDTH-1:1]}, Borrow←br_next, state→DONE.
- Diff and Borrow hold their value until the next completion. Only completion edges update them.
- start in RUN is ignored, with no queuing. Operand changes in RUN have no effect.
- Counter width is clog2(WIDTH)+1 bits. No wrap occurs within an operation.
- Arithmetic is unsigned. Results with Borrow=1 are the two's-complement wrap.

## Timing
- Reset (rst_n=0, any time, including mid-RUN), effective immediately and asynchronously:
  - state=IDLE, busy=0, done=0, Diff=0, Borrow=0, and all internal registers 0.
  - An in-flight operation is discarded and produces no done.
- The first rising edge after rst_n deasserts may accept start.
- Latency: start accepted at edge E0.
  - busy=1 from E0 through edge E0+WIDTH.
  - Diff, Borrow and done=1 are valid after edge E0+WIDTH, for one cycle.
  - done falls at edge E0+WIDTH+1.
- Throughput: start held high during DONE is accepted back-to-back, giving one result per WIDTH+1 cycles.
- done and busy are never high together.
- busy and done are registered outputs with no combinational path from inputs.

## Test plan
- Reset, then A=60, B=50, Bin=0 with a 1-cycle start:
  - busy high for 8 cycles.
  - done pulses once, 8 edges after accept.
  - Diff=10, Borrow=0.
- A=100, B=100, Bin=1 → Diff=255, Borrow=1. A=0, B=0, Bin=1 → Diff=255, Borrow=1.
- A=255, B=255, Bin=0 → Diff=0, Borrow=0. A=200, B=20, Bin=0 → Diff=180, Borrow=0. A=5, B=11, Bin=1 → Diff=249, Borrow=1.
- Start pulsed again at RUN cycle 3 with different operands → ignored; only one done, carrying the original result.
- rst_n pulsed low at RUN cycle 4:
  - All outputs read 0 immediately, state is IDLE, and no done pulse occurs.
  - A following A=20, B=0, Bin=0 operation gives Diff=20, Borrow=0.
- Start held high continuously for three operations → done at edges E0+8, E0+17 and E0+26, each result correct.
- Random check: 1000 random A, B, Bin → {Borrow, Diff} equals A − B − Bin computed 9-bit.
- Cross-check with the adder: feed the adder's Sum and Carry back through this block and confirm A is recovered.
